// File: rtl/led_mux_display.sv
// rtl/led_mux_display.sv - multiplexed 7-seg driver with shadow latch, PWM brightness, optional blink (LED_BLINK_EN)
`timescale 1ns/1ps
module led_mux_display #(
    parameter int NDIG         = 8,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NDIG*8-1:0] digits,
    input  logic [NDIG-1:0]   dp,
    input  logic [3:0]        brightness,
`ifdef LED_BLINK_EN
    input  logic [NDIG-1:0]   blink_mask,
`endif
    output logic              frame_start,
    output logic [NDIG-1:0]   LEDen,
    output logic              LEDA,
    output logic              LEDB,
    output logic              LEDC,
    output logic              LEDD,
    output logic              LEDE,
    output logic              LEDF,
    output logic              LEDG,
    output logic              LEDDP
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(NDIG);
    localparam int OW = CW + 5;

    logic [CW-1:0]          ctr_q, ctr_d;
    logic [SW-1:0]          slot_q, slot_d;
    logic                   init_q, init_d;
    logic [NDIG-1:0][7:0]   sh_dig_q, sh_dig_d;
    logic [NDIG-1:0]        sh_dp_q, sh_dp_d;
    logic [3:0]             bri_q, bri_d;
    logic                   fs_q, fs_d;
    logic [NDIG-1:0]        en_q, en_d;
    logic [6:0]             seg_q, seg_d;
    logic                   ldp_q, ldp_d;
    logic                   load, last_ctr, last_slot, eligible;
    logic [OW-1:0]          on_time;

    // Returns lit segments, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] decode(input logic [7:0] c);
        case (c)
            8'h30:        decode = 7'b1111110;
            8'h31:        decode = 7'b0110000;
            8'h32:        decode = 7'b1101101;
            8'h33:        decode = 7'b1111001;
            8'h34:        decode = 7'b0110011;
            8'h35:        decode = 7'b1011011;
            8'h36:        decode = 7'b1011111;
            8'h37:        decode = 7'b1110000;
            8'h38:        decode = 7'b1111111;
            8'h39:        decode = 7'b1111011;
            8'h41, 8'h61: decode = 7'b1110111;
            8'h42, 8'h62: decode = 7'b0011111;
            8'h43, 8'h63: decode = 7'b1001110;
            8'h44, 8'h64: decode = 7'b0111101;
            8'h45, 8'h65: decode = 7'b1001111;
            8'h46, 8'h66: decode = 7'b1000111;
            8'h2D:        decode = 7'b0000001;
            default:      decode = 7'b0000000;
        endcase
    endfunction

`ifdef LED_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    logic [NDIG-1:0] sh_blink_q, sh_blink_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            phase_q, phase_d;

    // The load right after reset opens frame 0 and is not counted, so each phase spans BLINK_FRAMES frames.
    always_comb begin
        sh_blink_d = sh_blink_q;
        fcnt_d     = fcnt_q;
        phase_d    = phase_q;
        if (load) begin
            sh_blink_d = blink_mask;
            if (!init_q) begin
                if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                    fcnt_d  = '0;
                    phase_d = ~phase_q;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end
        eligible = ~(phase_q & sh_blink_q[slot_q]);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sh_blink_q <= '0;
            fcnt_q     <= '0;
            phase_q    <= 1'b0;
        end else begin
            sh_blink_q <= sh_blink_d;
            fcnt_q     <= fcnt_d;
            phase_q    <= phase_d;
        end
    end
`else
    assign eligible = 1'b1;
`endif

    always_comb begin
        last_ctr  = (ctr_q == CW'(REFRESH_DIV - 1));
        last_slot = (slot_q == SW'(NDIG - 1));
        load      = init_q | (last_ctr & last_slot);
        ctr_d     = last_ctr ? '0 : ctr_q + 1'b1;
        slot_d    = slot_q;
        if (last_ctr) slot_d = last_slot ? '0 : slot_q + 1'b1;
        init_d    = 1'b0;
        bri_d     = (ctr_q == '0) ? brightness : bri_q;
        sh_dig_d  = load ? digits : sh_dig_q;
        sh_dp_d   = load ? dp : sh_dp_q;
        fs_d      = load;
        seg_d     = ~decode(sh_dig_q[slot_q]);
        ldp_d     = ~sh_dp_q[slot_q];
        on_time   = ((OW'(bri_q) + OW'(1)) * OW'(REFRESH_DIV)) >> 4;
        en_d      = '1;
        if (eligible && (OW'(ctr_q) >= OW'(BLANK_CYC)) && (OW'(ctr_q) < on_time))
            en_d[slot_q] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ctr_q    <= '0;
            slot_q   <= '0;
            init_q   <= 1'b1;
            sh_dig_q <= {NDIG{8'h20}};
            sh_dp_q  <= '0;
            bri_q    <= '0;
            fs_q     <= 1'b0;
            en_q     <= '1;
            seg_q    <= '1;
            ldp_q    <= 1'b1;
        end else begin
            ctr_q    <= ctr_d;
            slot_q   <= slot_d;
            init_q   <= init_d;
            sh_dig_q <= sh_dig_d;
            sh_dp_q  <= sh_dp_d;
            bri_q    <= bri_d;
            fs_q     <= fs_d;
            en_q     <= en_d;
            seg_q    <= seg_d;
            ldp_q    <= ldp_d;
        end
    end

    assign frame_start = fs_q;
    assign LEDen       = en_q;
    assign {LEDA, LEDB, LEDC, LEDD, LEDE, LEDF, LEDG} = seg_q;
    assign LEDDP       = ldp_q;
endmodule
